mm_controller: RTL and testbench
================================

Name: mm_controller

Overview:
- Sequencing control stage that sits directly upstream of data_path in the matrix multiplier.
- Computes C = A x B for square DIM x DIM matrices held in row-major operand memories A and B.
- Generates the synchronous read addresses for A and B, and drives data_path's en_Mux, en_PPReg and en_FDReg so each dot product is accumulated and captured.
- Issues the write address and strobe that store each outData element into result memory C.

Parameters:
DIM, 3, matrix dimension; inner-product length and row/column count.
ADDR_WIDTH, 4, width of all memory addresses; must be >= clog2(DIM*DIM).

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  start request; sampled only in IDLE.
clear  input  1  synchronous abort; returns to IDLE.
resultIsInvalid  input  1  overflow flag from data_path, valid alongside outData.
rd_en  output  1  read strobe to A and B memories (1-cycle read latency).
addr_A  output  ADDR_WIDTH  A address = i*DIM+k.
addr_B  output  ADDR_WIDTH  B address = k*DIM+j.
en_Mux  output  1  to data_path: 0 = load fresh product, 1 = accumulate.
en_PPReg  output  1  to data_path partial-product register enable.
en_FDReg  output  1  to data_path final-data register enable.
wr_en_C  output  1  result memory write strobe.
addr_C  output  ADDR_WIDTH  result address = i*DIM+j.
busy  output  1  run in progress.
done  output  1  one-cycle pulse on the final result write.
err  output  1  sticky: some written element had resultIsInvalid=1.

Behaviour:
- Reset (reset_n low, asynchronous): every output 0; i=j=k=0; state IDLE.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, FINAL, WRITE.
- IDLE:
  - start=1 at an edge goes to ISSUE with i=j=k=0, busy=1, err cleared.
  - start is ignored in all other states.
- ISSUE (DIM cycles): rd_en=1; addresses for the current k; k increments each cycle; after k=DIM-1 goes to WAIT.
- Data alignment: memory data for address cycle t arrives in cycle t+1. en_PPReg=1 in the cycle after each rd_en cycle. en_Mux=0 only on the k=0 data cycle, 1 otherwise. Both come from a one-cycle delayed copy of rd_en and of (k==0).
- WAIT (1 cycle): rd_en=0; last data cycle (en_PPReg=1, en_Mux=1); then FINAL.
- FINAL (1 cycle): en_FDReg=1, en_PPReg=0, en_Mux=0; then WRITE.
- WRITE (1 cycle):
  - wr_en_C=1, addr_C=i*DIM+j.
  - If resultIsInvalid=1 in this cycle, err=1 from the next cycle.
  - j increments; at j=DIM-1, j wraps to 0 and i increments.
  - If this is the last element (i=j=DIM-1), done=1 this cycle and the next state is IDLE with busy=0. Otherwise the next state is ISSUE with k=0.
- Timing: each element takes DIM+3 cycles; a full run takes DIM*DIM*(DIM+3) cycles. With defaults this is 54 cycles: busy is high for cycles 1..54 after the start edge, and the last write/done is in cycle 54.
- Outside the cycles above, rd_en, en_PPReg, en_FDReg, wr_en_C and done are 0. Addresses hold their last value.
- clear=1 in any state: next cycle is IDLE, all strobes 0, busy=0, no done. err keeps its value. clear has priority over start in the same cycle.
- A start in the same cycle as done is ignored (state is still WRITE).
- err stays set after a run; it clears only on reset or the next accepted start.

Test Plan:
1. Hold reset_n low, then release with no start -> all outputs 0 indefinitely; busy=0.
2. Start pulse at edge E0 (DIM=3) -> first element:
   - cycles 1-3: rd_en=1, addr_A 0,1,2, addr_B 0,3,6.
   - cycles 2-4: en_PPReg=1, with en_Mux 0,1,1.
   - cycle 5: en_FDReg=1.
   - cycle 6: wr_en_C=1, addr_C=0.
3. Full run -> exactly 9 wr_en_C pulses with addr_C 0..8 in order.
   - Element (1,2): addr_A 3,4,5 and addr_B 2,5,8.
   - done=1 only in cycle 54; busy=0 from cycle 55.
4. start re-asserted in cycles 10 and 54 -> ignored, with no change to the sequence. Start in cycle 56 -> new run begins cycle 57 with addr_A=0.
5. resultIsInvalid=1 during the WRITE of element 4 (cycle 30) -> err=1 from cycle 31 through end of run. The run still completes with 9 writes. The next start clears err.
6. Abort cases:
   - clear=1 at cycle 20 -> from cycle 21 IDLE, all strobes 0, busy=0, no done.
   - Separately, reset_n low at cycle 20 -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mm_controller.sv
// Sequencing controller for the DIM x DIM matrix multiplier: walks (i, j, k),
// issues A/B reads, steers data_path's accumulate registers and writes C.
module mm_controller #(
    parameter int DIM        = 3,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  resultIsInvalid,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr_A,
    output logic [ADDR_WIDTH-1:0] addr_B,
    output logic                  en_Mux,
    output logic                  en_PPReg,
    output logic                  en_FDReg,
    output logic                  wr_en_C,
    output logic [ADDR_WIDTH-1:0] addr_C,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [CW-1:0]         IDX_LAST = CW'(DIM - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(DIM);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINAL,
        S_WRITE
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_i;
    logic [CW-1:0]         r_j;
    logic [CW-1:0]         r_k;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr_A;
    logic [ADDR_WIDTH-1:0] r_addr_B;
    logic                  r_en_mux;
    logic                  r_en_pp;
    logic                  r_en_fd;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_addr_C;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_k_last;
    logic w_j_last;
    logic w_i_last;
    logic w_last_elem;

    assign w_k_last    = (r_k == IDX_LAST);
    assign w_j_last    = (r_j == IDX_LAST);
    assign w_i_last    = (r_i == IDX_LAST);
    assign w_last_elem = w_i_last && w_j_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_row_base <= '0;
            r_rd_en    <= 1'b0;
            r_addr_A   <= '0;
            r_addr_B   <= '0;
            r_en_mux   <= 1'b0;
            r_en_pp    <= 1'b0;
            r_en_fd    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr_C   <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Memory data lags its address by one cycle, so the partial-product
            // controls are a delayed copy of the read strobe and of (k == 0).
            r_rd_en  <= 1'b0;
            r_en_pp  <= r_rd_en;
            r_en_mux <= r_rd_en && (r_k != '0);
            r_en_fd  <= 1'b0;
            r_wr_en  <= 1'b0;
            r_done   <= 1'b0;

            if (clear) begin
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_en_pp  <= 1'b0;
                r_en_mux <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_state    <= S_ISSUE;
                            r_i        <= '0;
                            r_j        <= '0;
                            r_k        <= '0;
                            r_row_base <= '0;
                            r_rd_en    <= 1'b1;
                            r_addr_A   <= '0;
                            r_addr_B   <= '0;
                            r_busy     <= 1'b1;
                            r_err      <= 1'b0;
                        end
                    end

                    S_ISSUE: begin
                        if (w_k_last) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_k      <= r_k + CW'(1);
                            r_rd_en  <= 1'b1;
                            r_addr_A <= r_addr_A + ADDR_WIDTH'(1);
                            r_addr_B <= r_addr_B + STRIDE;
                        end
                    end

                    S_WAIT: begin
                        r_state <= S_FINAL;
                        r_en_fd <= 1'b1;
                    end

                    S_FINAL: begin
                        r_state  <= S_WRITE;
                        r_wr_en  <= 1'b1;
                        r_addr_C <= r_row_base + ADDR_WIDTH'(r_j);
                        r_done   <= w_last_elem;
                    end

                    S_WRITE: begin
                        if (resultIsInvalid) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_elem) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ISSUE;
                            r_k     <= '0;
                            r_rd_en <= 1'b1;
                            if (w_j_last) begin
                                r_j        <= '0;
                                r_i        <= r_i + CW'(1);
                                r_row_base <= r_row_base + STRIDE;
                                r_addr_A   <= r_row_base + STRIDE;
                                r_addr_B   <= '0;
                            end else begin
                                r_j      <= r_j + CW'(1);
                                r_addr_A <= r_row_base;
                                r_addr_B <= ADDR_WIDTH'(r_j) + ADDR_WIDTH'(1);
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rd_en    = r_rd_en;
    assign addr_A   = r_addr_A;
    assign addr_B   = r_addr_B;
    assign en_Mux   = r_en_mux;
    assign en_PPReg = r_en_pp;
    assign en_FDReg = r_en_fd;
    assign wr_en_C  = r_wr_en;
    assign addr_C   = r_addr_C;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_mm_controller.sv
// Directed bench for mm_controller (DIM=3): full run timing, ignored starts,
// sticky err, clear abort and asynchronous reset.
module tb_mm_controller;

    localparam int DIM = 3;
    localparam int AW  = 4;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          clear;
    logic          resultIsInvalid;
    logic          rd_en;
    logic [AW-1:0] addr_A;
    logic [AW-1:0] addr_B;
    logic          en_Mux;
    logic          en_PPReg;
    logic          en_FDReg;
    logic          wr_en_C;
    logic [AW-1:0] addr_C;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;

    mm_controller #(.DIM(DIM), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .clear           (clear),
        .resultIsInvalid (resultIsInvalid),
        .rd_en           (rd_en),
        .addr_A          (addr_A),
        .addr_B          (addr_B),
        .en_Mux          (en_Mux),
        .en_PPReg        (en_PPReg),
        .en_FDReg        (en_FDReg),
        .wr_en_C         (wr_en_C),
        .addr_C          (addr_C),
        .busy            (busy),
        .done            (done),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected outputs for cycle c (1-based) of a run: each element spans
    // 6 cycles = 3 issue, 1 wait, 1 final, 1 write.
    task automatic check_cycle(input string run, input int c, input bit err_exp);
        int p, e, i, j;
        p = (c - 1) % 6;
        e = (c - 1) / 6;
        i = e / DIM;
        j = e % DIM;
        check_val($sformatf("%s c%0d rd_en", run, c), 32'(rd_en), 32'(p < 3));
        if (p < 3) begin
            check_val($sformatf("%s c%0d addr_A", run, c), 32'(addr_A), 32'(i * DIM + p));
            check_val($sformatf("%s c%0d addr_B", run, c), 32'(addr_B), 32'(p * DIM + j));
        end
        check_val($sformatf("%s c%0d en_PPReg", run, c), 32'(en_PPReg), 32'(p >= 1 && p <= 3));
        check_val($sformatf("%s c%0d en_Mux", run, c), 32'(en_Mux), 32'(p == 2 || p == 3));
        check_val($sformatf("%s c%0d en_FDReg", run, c), 32'(en_FDReg), 32'(p == 4));
        check_val($sformatf("%s c%0d wr_en_C", run, c), 32'(wr_en_C), 32'(p == 5));
        if (p == 5) begin
            check_val($sformatf("%s c%0d addr_C", run, c), 32'(addr_C), 32'(e));
        end
        check_val($sformatf("%s c%0d done", run, c), 32'(done), 32'(p == 5 && e == 8));
        check_val($sformatf("%s c%0d busy", run, c), 32'(busy), 32'd1);
        check_val($sformatf("%s c%0d err", run, c), 32'(err), 32'(err_exp));
        $display("%s cycle %0d: rd=%0d A=%0d B=%0d pp=%0d mux=%0d fd=%0d wr=%0d C=%0d done=%0d err=%0d",
                 run, c, rd_en, addr_A, addr_B, en_PPReg, en_Mux, en_FDReg, wr_en_C, addr_C, done, err);
    endtask

    task automatic check_idle(input string tag, input bit err_exp);
        check_val({tag, " rd_en"}, 32'(rd_en), 32'd0);
        check_val({tag, " en_PPReg"}, 32'(en_PPReg), 32'd0);
        check_val({tag, " en_Mux"}, 32'(en_Mux), 32'd0);
        check_val({tag, " en_FDReg"}, 32'(en_FDReg), 32'd0);
        check_val({tag, " wr_en_C"}, 32'(wr_en_C), 32'd0);
        check_val({tag, " done"}, 32'(done), 32'd0);
        check_val({tag, " busy"}, 32'(busy), 32'd0);
        check_val({tag, " err"}, 32'(err), 32'(err_exp));
    endtask

    task automatic check_addr_zero(input string tag);
        check_val({tag, " addr_A"}, 32'(addr_A), 32'd0);
        check_val({tag, " addr_B"}, 32'(addr_B), 32'd0);
        check_val({tag, " addr_C"}, 32'(addr_C), 32'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        clear           = 1'b0;
        resultIsInvalid = 1'b0;

        // Reset and idle with no start
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset", 1'b0);
        check_addr_zero("reset");
        reset_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            next_cycle();
            check_idle($sformatf("idle%0d", n), 1'b0);
            check_addr_zero($sformatf("idle%0d", n));
        end

        // Run 1: full run, stray starts at 10 and 54, invalid result at cycle 30
        start = 1'b1;
        for (int c = 1; c <= 54; c++) begin
            next_cycle();
            check_cycle("run1", c, c >= 31);
            if (wr_en_C) n_writes++;
            start           = (c == 10 || c == 54);
            resultIsInvalid = (c == 30);
        end
        check_val("run1 write count", 32'(n_writes), 32'd9);

        next_cycle();
        start = 1'b0;
        check_idle("run1 c55", 1'b1);
        next_cycle();
        check_idle("run1 c56", 1'b1);
        start = 1'b1;

        // Run 2: begins in cycle 57, err cleared; invalid on first write, clear at 20
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            check_cycle("run2", c, c >= 7);
            start           = 1'b0;
            resultIsInvalid = (c == 6);
            clear           = (c == 20);
        end
        for (int n = 21; n <= 24; n++) begin
            next_cycle();
            clear = 1'b0;
            check_idle($sformatf("run2 clear c%0d", n), 1'b1);
        end

        // Run 3: asynchronous reset in the middle of cycle 20
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            check_cycle("run3", c, 1'b0);
            start = 1'b0;
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("async reset", 1'b0);
        check_addr_zero("async reset");
        next_cycle();
        reset_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            check_idle($sformatf("post reset%0d", n), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
